// File: rtl/muldiv_unit.sv
// Iterative RV32/64 M-extension multiply/divide unit with valid/ready handshakes.
// Define MULDIV_FAST_MUL_EN to compute MUL* with a single-cycle multiplier.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   opb;
    logic [CW-1:0]     cnt;

    logic              is_div;
    logic              sgn1;
    logic              sgn2;
    logic              div0;
    logic              ovf;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res_nxt;

    assign in_ready  = (state == S_IDLE) && !kill && !rst;
    assign out_valid = (state == S_DONE);

    // MUL and MULHU both run unsigned; the low half is sign-agnostic.
    assign is_div = funct3[2];
    assign sgn1 = op1[XLEN-1] &
        (is_div ? !funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010));
    assign sgn2 = op2[XLEN-1] &
        (is_div ? !funct3[0] : (funct3 == 3'b001));
    assign mag1 = sgn1 ? -op1 : op1;
    assign mag2 = sgn2 ? -op2 : op2;

    assign div0 = is_div && (op2 == '0);
    assign ovf  = is_div && !funct3[0] && (op1 == MOST_NEG) && (op2 == '1);
    assign fast_res = div0 ? (funct3[1] ? op1 : '1)
                           : (funct3[1] ? '0  : op1);

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN:0]            fa;
    logic [XLEN:0]            fb;
    logic signed [2*XLEN-1:0] fprod;

    assign fa = {sgn1, op1};
    assign fb = {sgn2, op2};
    assign fprod = $signed({{(XLEN-1){fa[XLEN]}}, fa}) *
                   $signed({{(XLEN-1){fb[XLEN]}}, fb});
`endif

    // acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        shifted = acc[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, opb};
        acc_nxt = {sum, acc[XLEN-1:1]};
        if (op[2]) begin
            if (diff[XLEN])
                acc_nxt = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        prod = neg_q ? -acc_nxt : acc_nxt;
        quo  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem  = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        res_nxt = prod[XLEN-1:0];
        unique case (1'b1)
            op[2] &&  op[1]:     res_nxt = rem;
            op[2] && !op[1]:     res_nxt = quo;
            !op[2] && op != '0:  res_nxt = prod[2*XLEN-1:XLEN];
            default:             res_nxt = prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op    <= funct3;
                        neg_q <= sgn1 ^ sgn2;
                        neg_r <= sgn1;
                        acc   <= {{XLEN{1'b0}}, mag1};
                        opb   <= mag2;
                        cnt   <= '0;
                        if (div0 || ovf) begin
                            result <= fast_res;
                            state  <= S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div) begin
                            result <= (funct3 == 3'b000)
                                ? fprod[XLEN-1:0]
                                : fprod[2*XLEN-1:XLEN];
                            state  <= S_DONE;
                        end
`endif
                        else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result <= res_nxt;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative integer multiply/divide unit implementing the RISC-V M-extension operations for XLEN = 32 or 64. It sits in the Execute stage beside the single-cycle ALU. It accepts one operation at a time through a valid/ready handshake and returns the result through a second valid/ready handshake. Multi-cycle operations stall the pipeline via `in_ready`/`out_valid`. A `kill` input discards in-flight work on a pipeline flush.

## Interface
- `XLEN`, 32, operand/result width; legal values 32 and 64.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `kill`  in  1  synchronous flush; abandons any operation.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1`  in  XLEN  rs1 value (multiplicand / dividend).
- `op2`  in  XLEN  rs2 value (multiplier / divisor).
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  operation result.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Outputs while `rst`=1 and one cycle after: `out_valid`=0, `result`=0, `in_ready`=0 while `rst`=1.
- `in_ready` = (state==IDLE) && !`kill` && !`rst`. It is combinational.
- Accept occurs when `in_valid` && `in_ready`. On accept the unit latches `funct3`:
  - signedness per op: MULH uses signed×signed; MULHSU uses signed `op1` × unsigned `op2`; DIV/REM are signed.
  - operand magnitudes, and the result sign: product sign = sign1^sign2; quotient sign = sign1^sign2; remainder sign = sign1.
  - the step counter, cleared to 0. The counter is $clog2(XLEN)+1 bits.
- Division fast paths apply on accept and go directly to DONE:
  - divisor 0: quotient all-ones, remainder = `op1`.
  - signed overflow (`op1` = most-negative, `op2` = -1): quotient = `op1`, remainder 0.
- Otherwise the unit enters CALC:
  - Multiply: radix-2 shift-add, one bit per cycle into a 2·XLEN accumulator.
  - Divide: radix-2 restoring, one quotient bit per cycle.
  - After XLEN steps the unit applies the sign fix (two's-complement negate if required) and selects the result:
    - MUL: low XLEN bits.
    - MULH*: high XLEN bits.
    - DIV*: quotient.
    - REM*: remainder.
  - The selected value is registered into `result`, and the state goes to DONE.
- DONE: `out_valid`=1, and `result` is held stable until `out_ready`=1. The unit then returns to IDLE, and `out_valid` drops on the next cycle.
- `kill`=1 in any state forces IDLE on the next edge and clears `out_valid`. The operation is discarded. `kill` has priority over accept and over the output handshake.
- `rst` has priority over everything, including `kill`.
- No overlap: a new request is never accepted while in CALC or DONE.

## Timing
- Cycle numbering: the accept cycle is cycle 0.
- Iterative path: state is CALC in cycles 1..XLEN, and `out_valid`=1 from cycle XLEN+1. That is 33 cycles for XLEN=32 and 65 cycles for XLEN=64.
- Division fast path: `out_valid`=1 in cycle 1.
- Fast-multiply configuration (see below): all MUL* operations have `out_valid`=1 in cycle 1.
- Minimum request-to-request spacing is latency+1 cycles: the DONE→IDLE cycle is followed by an IDLE accept.
- `result` changes only on the CALC→DONE or IDLE→DONE transition, or on reset.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU are computed with one 2·XLEN-bit combinational signed multiply. The multiply uses (XLEN+1)-bit sign-/zero-extended operands.
  - The product is registered on accept; IDLE→DONE.
  - Division is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: multiplication uses the iterative shift-add path with XLEN+1 cycle latency. No hardware multiplier is inferred.
- The interface, handshake, and results are identical in both builds; only latency differs.

## Test plan
- MUL `op1`=7, `op2`=0xFFFFFFFD (XLEN=32): `result`=0xFFFFFFEB. `out_valid` in cycle 33 without the macro, cycle 1 with it. `in_ready`=0 from cycle 1 until the output handshake.
- Upper-half multiplies (XLEN=32):
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides: DIV −7/2 → 0xFFFFFFFD; REM −7%2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100%7 → 2. `out_valid` in cycle 33.
- Division corners, each with `out_valid` in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5%0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. `result` stays stable, `out_valid`=1, `in_ready`=0. Raise `out_ready`: `out_valid`=0 and `in_ready`=1 on the next cycle, and a queued request is accepted.
- Flush/reset:
  - Assert `kill` in cycle 10 of a DIV: no `out_valid` ever; `in_ready`=1 in cycle 11.
  - Assert `kill` together with `in_valid` in IDLE: nothing is accepted.
  - Assert `rst` mid-CALC: `out_valid`=0 and `result`=0 after the edge.
